multiplier: RTL and testbench
=============================

// Module: multiplier
// PURPOSE
//  Multi-cycle RV32M multiply unit (MUL/MULH/MULHSU/MULHU), the multiply-side counterpart of the divider.
//  Sits in EX beside the ALU; accepts one op per start pulse, returns a 32-bit result with a done pulse.
//  Computes on operand magnitudes with shift-add; a final cycle applies the sign. Pipeline stalls while busy.
// PARAMETERS
//  XLEN  32  operand/result width; only 32 is supported
// PORTS
//  clk                input   1     clock, all state on rising edge
//  rst_n              input   1     asynchronous active-low reset
//  start              input   1     request, sampled only in IDLE
//  alucode            input   6     `ALU_MUL/`ALU_MULH/`ALU_MULHSU/`ALU_MULHU (define.vh), sampled with start
//  op1                input   32    rs1 value, sampled with start
//  op2                input   32    rs2 value, sampled with start
//  kill               input   1     pipeline flush; aborts the op in progress
//  busy               output  1     high in CALC and FIX
//  done               output  1     one-cycle pulse in DONE; result valid
//  multiplier_result  output  32    result; holds until the next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, multiplier_result=0, all datapath regs 0.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  IDLE: start=1 with a multiply alucode -> latch op, a=|op1|, b=|op2|, neg, count=0; go CALC.
//   - signed op1: MULH, MULHSU. signed op2: MULH only. MUL and MULHU treat both operands as unsigned.
//   - |0x80000000| = 0x80000000 (32-bit unsigned magnitude; no overflow).
//   - neg = (op1 signed & op1[31]) ^ (op2 signed & op2[31]).
//   - start with a non-multiply alucode is ignored; remain IDLE, no done.
//  CALC: 64-bit acc += (b[0] ? a<<count : 0); b >>= 1; count++. Exits to FIX after 32 iterations.
//  FIX: prod = neg ? -acc : acc (64-bit two's complement).
//   - result = prod[31:0] for MUL; prod[63:32] for all MULH* ops. Registered into multiplier_result.
//  DONE: done=1 for exactly one cycle, busy=0; next state is IDLE.
//   - start in DONE is not accepted; it is accepted from the following IDLE cycle.
//  Latency: start sampled at edge N -> done high in cycle after edge N+34 (radix-2).
//  start while busy: ignored; operands not re-sampled.
//  kill: highest priority in every state. Next edge -> IDLE, busy=0, no done.
//   - multiplier_result keeps its previous value.
//   - kill and start in the same IDLE cycle: start dropped.
//  Zero operand(s): no early-out; full latency; result 0 (negation of 0 is 0).
//  Reset mid-operation: immediate return to reset values, no done.
// CONFIGURATION
//  MUL_RADIX4_EN defined: CALC retires 2 multiplier bits per cycle.
//   - acc += (b[0]?a<<count:0) + (b[1]?a<<(count+1):0); b >>= 2; count += 2.
//   - 16 iterations; start->done latency 18. Results bit-identical to radix-2.
//  MUL_RADIX4_EN undefined: radix-2, 32 iterations, latency 34.
// TESTING
//  MUL 7 x 0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done exactly 34 (18 radix-4) cycles after start, one cycle wide.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  MULHSU 0xFFFFFFFF (-1) x 0xFFFFFFFF -> 0xFFFFFFFF; MULH 0xFFFFFFFF x 5 -> 0xFFFFFFFF; MULH 0 x 0x80000000 -> 0.
//  start with new operands at cycle 5 of a busy op -> ignored; first result unchanged; busy stays high until FIX ends.
//  Kill at cycle 10 of CALC -> IDLE next edge, busy=0, no done, result keeps previous value.
//   - then MUL 3 x 4 -> 12 at full latency.
//  Assert rst_n mid-CALC -> busy/done/result 0 immediately.
//   - start with alucode `ALU_DIV -> no busy, no done.
//  Random: 10k random ops, both configs, checked against a 64-bit reference product.

Source files
------------

// File: rtl/multiplier_if.sv
// Request/response bundle between the EX stage and the multi-cycle multiply unit.
// The master (pipeline) drives the request and kill; the slave (multiplier) drives the status and result.
interface multiplier_if;
    logic        start;
    logic [5:0]  alucode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] multiplier_result;

    modport master (
        output start, alucode, op1, op2, kill,
        input  busy, done, multiplier_result
    );

    modport slave (
        input  start, alucode, op1, op2, kill,
        output busy, done, multiplier_result
    );
endinterface

// File: rtl/multiplier.sv
// Multi-cycle RV32M multiplier (MUL/MULH/MULHSU/MULHU): shift-add on operand magnitudes, sign fixed at the end.
// Define MUL_RADIX4_EN to retire two multiplier bits per CALC cycle (radix-4); default is radix-2.
module multiplier #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    multiplier_if.slave bus
);
    localparam logic [5:0] ALU_MUL    = 6'd32;
    localparam logic [5:0] ALU_MULH   = 6'd33;
    localparam logic [5:0] ALU_MULHSU = 6'd34;
    localparam logic [5:0] ALU_MULHU  = 6'd35;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [5:0] COUNT_END = 6'd32;
`ifdef MUL_RADIX4_EN
    localparam logic [5:0] STEP = 6'd2;
`else
    localparam logic [5:0] STEP = 6'd1;
`endif

    logic [1:0]  state_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [63:0] acc_reg;
    logic [5:0]  count_reg;
    logic        neg_reg;
    logic        hi_sel_reg;
    logic [31:0] result_reg;

    logic        is_mul_op;
    logic        op1_signed;
    logic        op2_signed;
    logic        op1_neg;
    logic        op2_neg;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [63:0] a_ext;
    logic [63:0] addend;
    logic [63:0] prod;

    always_comb begin
        is_mul_op  = (bus.alucode == ALU_MUL)  || (bus.alucode == ALU_MULH) ||
                     (bus.alucode == ALU_MULHSU) || (bus.alucode == ALU_MULHU);
        op1_signed = (bus.alucode == ALU_MULH) || (bus.alucode == ALU_MULHSU);
        op2_signed = (bus.alucode == ALU_MULH);
        op1_neg    = op1_signed && bus.op1[31];
        op2_neg    = op2_signed && bus.op2[31];
        // 0x80000000 negates to itself, which is its correct unsigned magnitude
        mag1       = op1_neg ? (~bus.op1 + 32'd1) : bus.op1;
        mag2       = op2_neg ? (~bus.op2 + 32'd1) : bus.op2;
    end

    always_comb begin
        a_ext  = {32'd0, a_reg};
        addend = b_reg[0] ? (a_ext << count_reg) : 64'd0;
`ifdef MUL_RADIX4_EN
        addend = addend + (b_reg[1] ? (a_ext << (count_reg + 6'd1)) : 64'd0);
`endif
        prod   = neg_reg ? (~acc_reg + 64'd1) : acc_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            neg_reg    <= 1'b0;
            hi_sel_reg <= 1'b0;
            result_reg <= '0;
        end else if (bus.kill) begin
            // flush wins over everything, including a start in the same cycle
            state_reg <= S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start && is_mul_op) begin
                        a_reg      <= mag1;
                        b_reg      <= mag2;
                        acc_reg    <= '0;
                        count_reg  <= '0;
                        neg_reg    <= op1_neg ^ op2_neg;
                        hi_sel_reg <= (bus.alucode != ALU_MUL);
                        state_reg  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (count_reg == COUNT_END) begin
                        state_reg <= S_FIX;
                    end else begin
                        acc_reg   <= acc_reg + addend;
                        b_reg     <= b_reg >> STEP;
                        count_reg <= count_reg + STEP;
                    end
                end
                S_FIX: begin
                    result_reg <= hi_sel_reg ? prod[63:32] : prod[31:0];
                    state_reg  <= S_DONE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy              = (state_reg == S_CALC) || (state_reg == S_FIX);
    assign bus.done              = (state_reg == S_DONE);
    assign bus.multiplier_result = result_reg;
endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for the multiplier: results, latency, done width, busy window, kill, reset, ignored starts.
module tb_multiplier;
    localparam logic [5:0] ALU_MUL    = 6'd32;
    localparam logic [5:0] ALU_MULH   = 6'd33;
    localparam logic [5:0] ALU_MULHSU = 6'd34;
    localparam logic [5:0] ALU_MULHU  = 6'd35;
    localparam logic [5:0] ALU_DIV    = 6'd36;
`ifdef MUL_RADIX4_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 34;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    multiplier_if bus ();

    multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE and follow it to done; optionally poke a second start mid-CALC.
    task automatic run_op(input string tag, input logic [5:0] code, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input bit poke);
        int lat;
        int busy_cnt;
        bus.start   = 1'b1;
        bus.alucode = code;
        bus.op1     = x;
        bus.op2     = y;
        step();
        bus.start = 1'b0;
        bus.op1   = $urandom;
        bus.op2   = $urandom;
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= LAT + 10; k++) begin
            step();
            if (poke && k == 5) begin
                bus.start   = 1'b1;
                bus.alucode = ALU_MUL;
                bus.op1     = 32'd3;
                bus.op2     = 32'd4;
            end
            if (poke && k == 6) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(LAT - 1));
        check({tag, " result"}, {32'd0, bus.multiplier_result}, {32'd0, exp});
        step();
        check({tag, " done width"}, {63'd0, bus.done}, 64'd0);
        $display("op %s code=%0d op1=%h op2=%h result=%h latency=%0d", tag, code, x, y,
                 bus.multiplier_result, lat);
    endtask

    function automatic logic [31:0] ref_mul(input logic [5:0] code, input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0] sx, ux, sy, uy, p;
        sx = {{32{x[31]}}, x};
        ux = {32'd0, x};
        sy = {{32{y[31]}}, y};
        uy = {32'd0, y};
        case (code)
            ALU_MULH:   p = sx * sy;
            ALU_MULHSU: p = sx * uy;
            ALU_MULHU:  p = ux * uy;
            default:    p = ux * uy;
        endcase
        return (code == ALU_MUL) ? p[31:0] : p[63:32];
    endfunction

    initial begin
        int seen;
        logic [31:0] prev;
        logic [5:0]  codes [4];
        n_vec = 0;
        n_err = 0;
        codes[0] = ALU_MUL;
        codes[1] = ALU_MULH;
        codes[2] = ALU_MULHSU;
        codes[3] = ALU_MULHU;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.kill    = 1'b0;
        bus.alucode = 6'd0;
        bus.op1     = 32'd0;
        bus.op2     = 32'd0;
        repeat (2) step();
        check("reset busy", {63'd0, bus.busy}, 64'd0);
        check("reset done", {63'd0, bus.done}, 64'd0);
        check("reset result", {32'd0, bus.multiplier_result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op("mul_7_m3",        ALU_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("mulh_min_min",    ALU_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 1'b0);
        run_op("mulhu_max_max",   ALU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("mulhsu_m1_max",   ALU_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("mulh_m1_5",       ALU_MULH,   32'hFFFFFFFF,   32'd5,        32'hFFFFFFFF, 1'b0);
        run_op("mulh_0_min",      ALU_MULH,   32'd0,          32'h80000000, 32'd0,        1'b0);
        run_op("mulh_maxpos",     ALU_MULH,   32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 1'b0);
        run_op("mulhsu_min_2p31", ALU_MULHSU, 32'h80000000,   32'h80000000, 32'hC0000000, 1'b0);
        run_op("mulhu_2p31_2",    ALU_MULHU,  32'h80000000,   32'd2,        32'd1,        1'b0);
        run_op("mul_2p16_2p16",   ALU_MUL,    32'h00010000,   32'h00010000, 32'd0,        1'b0);
        run_op("mul_m1_m1",       ALU_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        1'b0);

        // second start while busy must be ignored
        run_op("mul_poke",        ALU_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
        step();
        check("poke no restart", {63'd0, bus.busy}, 64'd0);

        // kill at cycle 10 of CALC
        prev = bus.multiplier_result;
        bus.start = 1'b1; bus.alucode = ALU_MUL; bus.op1 = 32'h1234; bus.op2 = 32'h5678;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        check("kill pre busy", {63'd0, bus.busy}, 64'd1);
        bus.kill = 1'b1;
        step();
        bus.kill = 1'b0;
        check("kill busy", {63'd0, bus.busy}, 64'd0);
        check("kill result", {32'd0, bus.multiplier_result}, {32'd0, prev});
        seen = 0;
        for (int k = 0; k < LAT + 5; k++) begin
            step();
            if (bus.done || bus.busy) seen++;
        end
        check("kill no done", 64'(seen), 64'd0);
        $display("op kill_mid_calc result=%h", bus.multiplier_result);
        run_op("mul_3_4",         ALU_MUL,    32'd3,          32'd4,        32'd12,       1'b0);

        // kill and start in the same IDLE cycle: start dropped
        bus.start = 1'b1; bus.kill = 1'b1; bus.alucode = ALU_MUL; bus.op1 = 32'd9; bus.op2 = 32'd9;
        step();
        bus.start = 1'b0; bus.kill = 1'b0;
        check("kill+start busy", {63'd0, bus.busy}, 64'd0);
        $display("op kill_with_start busy=%b", bus.busy);

        // non-multiply alucode is ignored
        bus.start = 1'b1; bus.alucode = ALU_DIV; bus.op1 = 32'd100; bus.op2 = 32'd7;
        step();
        bus.start = 1'b0;
        seen = 0;
        for (int k = 0; k < LAT + 5; k++) begin
            step();
            if (bus.done || bus.busy) seen++;
        end
        check("div ignored", 64'(seen), 64'd0);
        $display("op alu_div_ignored activity=%0d", seen);

        // async reset mid-CALC
        bus.start = 1'b1; bus.alucode = ALU_MULHU; bus.op1 = 32'hFFFFFFFF; bus.op2 = 32'hFFFFFFFF;
        step();
        bus.start = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check("rst busy", {63'd0, bus.busy}, 64'd0);
        check("rst done", {63'd0, bus.done}, 64'd0);
        check("rst result", {32'd0, bus.multiplier_result}, 64'd0);
        $display("op reset_mid_calc result=%h", bus.multiplier_result);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // short random sweep against a 64-bit reference product
        for (int i = 0; i < 16; i++) begin
            logic [31:0] x, y;
            logic [5:0]  c;
            x = $urandom;
            y = $urandom;
            if (i % 4 == 0) x = {x[31], 31'd0};
            c = codes[i % 4];
            run_op($sformatf("rand%0d", i), c, x, y, ref_mul(c, x, y), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
